// File: rtl/char_fetch.sv
// char_fetch: streams an inclusive scratchpad address range out through a credit-managed FIFO
module char_fetch #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH-1:0] end_addr,
    output logic                  busy,
    output logic                  mem_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  done
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] end_q, end_d;
    logic                  done_q, done_d;
    logic                  inflight_q, inflight_last_q;
    logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_last_q;
    logic [PW-1:0]         wptr_q, rptr_q;
    logic [CW-1:0]         count_q;
    logic                  credit_ok, push, pop, last_pop;

    // Issue gating: reads in the FIFO plus the one returning must leave room for another
    always_comb begin
        credit_ok = (count_q + CW'(inflight_q)) < CW'(FIFO_DEPTH);
        mem_en    = (state_q == FETCH) && credit_ok;
        mem_addr  = addr_q;
        busy      = state_q != IDLE;
        done      = done_q;
        out_valid = count_q != '0;
        out_data  = out_valid ? fifo_data_q[rptr_q] : '0;
        out_last  = out_valid && fifo_last_q[rptr_q];
        push      = inflight_q;
        pop       = out_valid && out_ready;
        last_pop  = pop && fifo_last_q[rptr_q] && (state_q == DRAIN);
    end

    // Next-state logic: range capture, address walk with wrap, drain until last word leaves
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        end_d   = end_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FETCH;
                    addr_d  = start_addr;
                    end_d   = end_addr;
                end
            end
            FETCH: begin
                if (mem_en) begin
                    if (addr_q == end_q) state_d = DRAIN;
                    else addr_d = addr_q + ADDR_WIDTH'(1);
                end
            end
            DRAIN: begin
                if (last_pop) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control registers, return-path tracking and FIFO bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            end_q           <= '0;
            done_q          <= 1'b0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            fifo_last_q     <= '0;
            wptr_q          <= '0;
            rptr_q          <= '0;
            count_q         <= '0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            end_q           <= end_d;
            done_q          <= done_d;
            inflight_q      <= mem_en;
            inflight_last_q <= mem_en && (addr_q == end_q);
            if (push) fifo_last_q[wptr_q] <= inflight_last_q;
            if (push) wptr_q <= wptr_q + PW'(1);
            if (pop) rptr_q <= rptr_q + PW'(1);
            count_q         <= count_q + CW'(push) - CW'(pop);
        end
    end

    // FIFO payload storage; contents are masked by out_valid so no reset is needed
    always_ff @(posedge clk) begin
        if (push) fifo_data_q[wptr_q] <= mem_rdata;
    end

    // The credit rule must make a write into a full FIFO impossible
    assert property (@(posedge clk) disable iff (!rst_n) push |-> (count_q < CW'(FIFO_DEPTH)));

endmodule

// File: tb/tb_char_fetch.sv
// tb_char_fetch: directed checks of range streaming, wrap, backpressure, restart-ignore and reset
module tb_char_fetch;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] start_addr = '0;
    logic [3:0] end_addr = '0;
    logic       out_ready = 1'b0;
    logic [7:0] mem_rdata = '0;
    logic       busy, mem_en, out_valid, out_last, done;
    logic [3:0] mem_addr;
    logic [7:0] out_data;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int addrq[$];
    int dq[$];
    int lq[$];
    int cq[$];
    int issued = 0;
    int popped = 0;
    int maxout = 0;
    int donecnt = 0;
    int done_cyc = 0;
    int first_valid = -1;
    int s_cyc = 0;

    char_fetch #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr), .end_addr(end_addr),
        .busy(busy), .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) if (mem_en) mem_rdata <= 8'(mem_addr) * 8'd3;

    always @(negedge clk) begin
        if (mem_en) begin
            addrq.push_back(int'(mem_addr));
            issued++;
        end
        if (issued - popped > maxout) maxout = issued - popped;
        if (out_valid && first_valid < 0) first_valid = cyc;
        if (out_valid && out_ready) begin
            dq.push_back(int'(out_data));
            lq.push_back(int'(out_last));
            cq.push_back(cyc);
            popped++;
        end
        if (done) begin
            donecnt++;
            done_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic go(input int s, input int e, input int mode);
        addrq.delete(); dq.delete(); lq.delete(); cq.delete();
        issued = 0; popped = 0; maxout = 0; donecnt = 0; first_valid = -1;
        start = 1'b1; start_addr = 4'(s); end_addr = 4'(e);
        out_ready = (mode != 1);
        s_cyc = cyc + 1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_rise", int'(busy), 1);
        for (int n = 0; n < 300 && donecnt == 0; n++) begin
            if (mode == 1) begin
                if (n == 10) chk("stall_reads", issued, 4);
                out_ready = (n < 10) ? 1'b0 : 1'($urandom_range(0, 1));
            end
            if (mode == 2) begin
                start = (n == 2);
                start_addr = 4'd9;
                end_addr = 4'd12;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        chk("done_seen", donecnt, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("done_once", donecnt, 1);
        chk("busy_fall", int'(busy), 0);
    endtask

    task automatic check_stream(input int s, input int e, input string p);
        int n;
        int a;
        n = ((e - s) & 15) + 1;
        chk($sformatf("%s_nwords", p), dq.size(), n);
        chk($sformatf("%s_nreads", p), addrq.size(), n);
        for (int i = 0; i < n; i++) begin
            a = (s + i) & 15;
            if (i < addrq.size()) chk($sformatf("%s_addr%0d", p, i), addrq[i], a);
            if (i < dq.size()) begin
                chk($sformatf("%s_data%0d", p, i), dq[i], (a * 3) & 255);
                chk($sformatf("%s_last%0d", p, i), lq[i], int'(i == n - 1));
            end
        end
        chk($sformatf("%s_maxout_le4", p), int'(maxout <= 4), 1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_mem_en", int'(mem_en), 0);
        chk("rst_mem_addr", int'(mem_addr), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_last", int'(out_last), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_done", int'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        go(2, 5, 0);
        check_stream(2, 5, "t1");
        chk("t1_first_valid", first_valid, s_cyc + 2);
        for (int i = 0; i < cq.size(); i++) chk($sformatf("t1_pop_cyc%0d", i), cq[i], s_cyc + 2 + i);
        if (cq.size() > 0) chk("t1_done_cyc", done_cyc, cq[cq.size() - 1] + 1);

        go(14, 1, 0);
        check_stream(14, 1, "t2");

        go(7, 7, 0);
        check_stream(7, 7, "t3");
        if (cq.size() > 0) chk("t3_done_cyc", done_cyc, cq[0] + 1);

        go(0, 15, 1);
        check_stream(0, 15, "t4");

        go(2, 5, 2);
        check_stream(2, 5, "t5");

        addrq.delete(); dq.delete(); lq.delete(); cq.delete();
        issued = 0; popped = 0; maxout = 0; donecnt = 0;
        start = 1'b1; start_addr = 4'd0; end_addr = 4'd15; out_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("t6_pre_reads", issued, 4);
        chk("t6_pre_valid", int'(out_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_busy", int'(busy), 0);
        chk("t6_rst_mem_en", int'(mem_en), 0);
        chk("t6_rst_mem_addr", int'(mem_addr), 0);
        chk("t6_rst_out_valid", int'(out_valid), 0);
        chk("t6_rst_out_last", int'(out_last), 0);
        chk("t6_rst_out_data", int'(out_data), 0);
        chk("t6_rst_done", int'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("t6_no_done", donecnt, 0);
        go(3, 6, 0);
        check_stream(3, 6, "t6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
